mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, meaning: maximum cycles a grant may wait for RAM ACCESS before abort (legal range 2..255).
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 iREN  in  1  instruction read request from icache.
REQ-005 iaddr  in  32  instruction word address.
REQ-006 iwait  out  1  instruction stall; 0 only in the instruction completion cycle.
REQ-007 iload  out  32  instruction read data.
REQ-008 dREN  in  1  data read request from dcache.
REQ-009 dWEN  in  1  data write request from dcache.
REQ-010 daddr  in  32  data word address.
REQ-011 dstore  in  32  data write value.
REQ-012 dwait  out  1  data stall; 0 only in the data completion cycle.
REQ-013 dload  out  32  data read data.
REQ-014 ramREN  out  1  RAM read enable.
REQ-015 ramWEN  out  1  RAM write enable.
REQ-016 ramaddr  out  32  RAM address.
REQ-017 ramstore  out  32  RAM write data.
REQ-018 ramload  in  32  RAM read data.
REQ-019 ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-020 err  out  1  sticky error flag: RAM ERROR or timeout seen.

Function
REQ-021 FSM states IDLE, IGRANT, DGRANT, held in a register; RAM outputs decode from the registered state, giving exactly one cycle of arbitration latency.
REQ-022 IDLE: all RAM enables 0, ramaddr = 0, ramstore = 0, iwait = dwait = 1.
REQ-023 IDLE -> DGRANT when (dREN|dWEN) and not (last_d and iREN); else IDLE -> IGRANT when iREN; else stay IDLE.
REQ-024 last_d: register set to 1 on DGRANT completion, cleared to 0 on IGRANT completion; ensures data priority with forced alternation when both request.
REQ-025 IGRANT: ramREN = iREN, ramWEN = 0, ramaddr = iaddr, ramstore = 0.
REQ-026 DGRANT: ramWEN = dWEN, ramREN = dREN & ~dWEN (write wins if both asserted), ramaddr = daddr, ramstore = dstore.
REQ-027 Completion: in a grant state with ramstate == ACCESS, the granted side's wait = 0 for that cycle; next state IDLE.
REQ-028 iload = ramload and dload = ramload at all times (combinational passthrough; valid only when the matching wait is 0).
REQ-029 The non-granted side's wait stays 1 throughout any grant.
REQ-030 Requester drop: granted side deasserts all its enables before ACCESS -> next state IDLE, no wait pulse, last_d unchanged.
REQ-031 ERROR: ramstate == ERROR in a grant state -> wait stays 1, err set to 1, next state IDLE, last_d unchanged (requester retries).
REQ-032 Timeout: 8-bit counter cleared on grant entry, increments each grant cycle without ACCESS; when it reaches TIMEOUT-1 without ACCESS -> err = 1, next IDLE, wait stays 1.
REQ-033 ACCESS and timeout in the same cycle: ACCESS wins, no err.
REQ-034 err clears only on reset.
REQ-035 Requests arriving in a completion cycle are considered from IDLE the following cycle (minimum 2-cycle turnaround between grants).

Reset
REQ-036 RST = 1 at a clock edge -> state IDLE, last_d = 0, counter = 0, err = 0; next cycle ramREN = ramWEN = 0, ramaddr = 0, ramstore = 0, iwait = dwait = 1.
REQ-037 RST mid-grant aborts the transfer with no wait pulse; RST takes priority over every other transition.

Verification
REQ-038 iREN = 1, iaddr = 0x40, ramstate ACCESS on 2nd grant cycle, ramload = 0xDEADBEEF -> ramREN = 1 one cycle after request, iwait = 0 with iload = 0xDEADBEEF exactly one cycle, then IDLE.
REQ-039 iREN and dWEN asserted together continuously, RAM ACCESS after 1 BUSY cycle -> grants alternate D, I, D, I; ramWEN = 1 with daddr/dstore in D grants; ramREN = 1 in I grants.
REQ-040 dREN = dWEN = 1, daddr = 0x100, dstore = 0x12345678 -> ramWEN = 1, ramREN = 0, ramstore = 0x12345678.
REQ-041 TIMEOUT = 4, ramstate held BUSY -> err = 1 after the 4th grant cycle, dwait never 0, FSM IDLE, err remains 1 until RST.
REQ-042 ramstate = ERROR during IGRANT -> err = 1, iwait stays 1, re-grant of pending iREN one cycle later.
REQ-043 RST asserted in the 2nd DGRANT cycle -> next cycle ramWEN = 0, dwait = 1, err = 0, last_d = 0 (a following simultaneous iREN/dREN grants data first).

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single-ported RAM.
// One-cycle arbitration latency, data priority with forced alternation, sticky error on RAM ERROR or timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,

    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,

    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,

    output logic        err,

    output logic [1:0]  dbg_state,
    output logic        dbg_last_d
);

    // Handshake: a requester holds its enable(s) and address until it sees its
    // wait low for one cycle; that cycle carries the read data. Dropping the
    // enables before then cancels the request without a wait pulse.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t     state;
    logic       last_d;
    logic [7:0] tmo_cnt;

    logic d_req;
    logic granted_active;
    logic access;

    assign d_req = dREN | dWEN;

    always_comb begin
        granted_active = 1'b0;
        case (state)
            IGRANT:  granted_active = iREN;
            DGRANT:  granted_active = d_req;
            default: granted_active = 1'b0;
        endcase
    end

    assign access = granted_active && (ramstate == RAM_ACCESS);

    // RAM side and wait outputs decode from the registered state only.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'h0;
        ramstore = 32'h0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = ~access;
            end
            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~access;
            end
            default: ;
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            tmo_cnt <= 8'h0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= 8'h0;
                    if (d_req && !(last_d && iREN)) state <= DGRANT;
                    else if (iREN)                 state <= IGRANT;
                end
                IGRANT, DGRANT: begin
                    if (!granted_active) begin
                        state <= IDLE;
                    end else if (ramstate == RAM_ACCESS) begin
                        state  <= IDLE;
                        last_d <= (state == DGRANT);
                    end else if (ramstate == RAM_ERROR || tmo_cnt == TMO_LAST) begin
                        // Abort; last_d is left alone so the same requester retries.
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state  = state;
    assign dbg_last_d = last_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge, outputs
// are sampled 1 ns later; completed reads are checked against an expected-data queue.
module tb_mem_arbiter;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;
    logic [1:0]  dbg_state;
    logic        dbg_last_d;

    int checks   = 0;
    int failures = 0;

    logic [31:0] iexp_q[$];
    logic [31:0] dexp_q[$];

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .daddr      (daddr),
        .dstore     (dstore),
        .dwait      (dwait),
        .dload      (dload),
        .ramREN     (ramREN),
        .ramWEN     (ramWEN),
        .ramaddr    (ramaddr),
        .ramstore   (ramstore),
        .ramload    (ramload),
        .ramstate   (ramstate),
        .err        (err),
        .dbg_state  (dbg_state),
        .dbg_last_d (dbg_last_d)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge CLK);
    endtask

    // scoreboard: any completion pops and compares the expected read data
    task automatic settle();
        #1;
        if (iwait === 1'b0) begin
            if (iexp_q.size() == 0) check("i_unexpected_done", 32'(iwait), 32'd1);
            else                    check("iload", iload, iexp_q.pop_front());
        end
        if (dwait === 1'b0) begin
            if (dexp_q.size() == 0) check("d_unexpected_done", 32'(dwait), 32'd1);
            else                    check("dload", dload, dexp_q.pop_front());
        end
    endtask

    // driver tasks
    task automatic idle_inputs();
        iREN     = 1'b0;
        iaddr    = 32'h0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = 32'h0;
        dstore   = 32'h0;
        ramload  = 32'h0;
        ramstate = FREE;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle_inputs();
        next();
        RST = 1'b0;
    endtask

    task automatic drive_access(input bit to_d);
        ramstate = ACCESS;
        ramload  = 32'($urandom_range(32'hFFFF_FFFF, 0));
        if (to_d) dexp_q.push_back(ramload);
        else      iexp_q.push_back(ramload);
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        next();
        next();
        RST = 1'b0;
        settle();
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_ramREN", 32'(ramREN), 32'd0);
        check("rst_ramWEN", 32'(ramWEN), 32'd0);
        check("rst_ramaddr", ramaddr, 32'h0);
        check("rst_ramstore", ramstore, 32'h0);
        check("rst_iwait", 32'(iwait), 32'd1);
        check("rst_dwait", 32'(dwait), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_last_d", 32'(dbg_last_d), 32'd0);
        next();

        // single instruction read, ACCESS on 2nd grant cycle
        iREN = 1'b1;
        iaddr = 32'h40;
        settle();
        check("a_idle_ramREN", 32'(ramREN), 32'd0);
        check("a_idle_iwait", 32'(iwait), 32'd1);
        next();
        ramstate = BUSY;
        settle();
        check("a_state_ig", 32'(dbg_state), 32'd1);
        check("a_ramREN", 32'(ramREN), 32'd1);
        check("a_ramWEN", 32'(ramWEN), 32'd0);
        check("a_ramaddr", ramaddr, 32'h40);
        check("a_iwait_busy", 32'(iwait), 32'd1);
        next();
        ramstate = ACCESS;
        ramload = 32'hDEAD_BEEF;
        iexp_q.push_back(32'hDEAD_BEEF);
        settle();
        check("a_iwait_done", 32'(iwait), 32'd0);
        check("a_dwait_done", 32'(dwait), 32'd1);
        next();
        iREN = 1'b0;
        ramstate = FREE;
        settle();
        check("a_after_state", 32'(dbg_state), 32'd0);
        check("a_after_iwait", 32'(iwait), 32'd1);
        check("a_last_d", 32'(dbg_last_d), 32'd0);
        next();

        // data requester drops before ACCESS: no pulse, last_d unchanged
        dREN = 1'b1;
        daddr = 32'h60;
        settle();
        next();
        ramstate = BUSY;
        settle();
        check("drop_state_dg", 32'(dbg_state), 32'd2);
        next();
        dREN = 1'b0;
        ramstate = ACCESS;
        settle();
        check("drop_dwait", 32'(dwait), 32'd1);
        next();
        ramstate = FREE;
        settle();
        check("drop_state", 32'(dbg_state), 32'd0);
        check("drop_last_d", 32'(dbg_last_d), 32'd0);
        next();

        // dREN and dWEN together: write wins
        dREN = 1'b1;
        dWEN = 1'b1;
        daddr = 32'h100;
        dstore = 32'h1234_5678;
        settle();
        next();
        ramstate = BUSY;
        settle();
        check("w_ramWEN", 32'(ramWEN), 32'd1);
        check("w_ramREN", 32'(ramREN), 32'd0);
        check("w_ramaddr", ramaddr, 32'h100);
        check("w_ramstore", ramstore, 32'h1234_5678);
        next();
        drive_access(1'b1);
        settle();
        check("w_dwait_done", 32'(dwait), 32'd0);
        next();
        idle_inputs();
        settle();
        check("w_last_d", 32'(dbg_last_d), 32'd1);
        next();

        // continuous iREN + dWEN: grants alternate D, I, D, I
        do_reset();
        iREN = 1'b1;
        iaddr = 32'h200;
        dWEN = 1'b1;
        daddr = 32'h300;
        dstore = 32'h55;
        for (int r = 0; r < 2; r++) begin
            ramstate = FREE;
            settle();
            check("alt_idle", 32'(dbg_state), 32'd0);
            next();
            ramstate = BUSY;
            settle();
            check("alt_dg_state", 32'(dbg_state), 32'd2);
            check("alt_dg_ramWEN", 32'(ramWEN), 32'd1);
            check("alt_dg_ramREN", 32'(ramREN), 32'd0);
            check("alt_dg_ramaddr", ramaddr, 32'h300);
            check("alt_dg_ramstore", ramstore, 32'h55);
            check("alt_dg_iwait", 32'(iwait), 32'd1);
            next();
            drive_access(1'b1);
            settle();
            check("alt_dg_done", 32'(dwait), 32'd0);
            check("alt_dg_iwait_done", 32'(iwait), 32'd1);
            next();
            ramstate = FREE;
            settle();
            check("alt_idle2", 32'(dbg_state), 32'd0);
            next();
            ramstate = BUSY;
            settle();
            check("alt_ig_state", 32'(dbg_state), 32'd1);
            check("alt_ig_ramREN", 32'(ramREN), 32'd1);
            check("alt_ig_ramWEN", 32'(ramWEN), 32'd0);
            check("alt_ig_ramaddr", ramaddr, 32'h200);
            check("alt_ig_ramstore", ramstore, 32'h0);
            check("alt_ig_dwait", 32'(dwait), 32'd1);
            next();
            drive_access(1'b0);
            settle();
            check("alt_ig_done", 32'(iwait), 32'd0);
            next();
        end
        idle_inputs();
        settle();
        next();

        // RAM ERROR during IGRANT: err set, retry after one IDLE cycle
        iREN = 1'b1;
        iaddr = 32'h44;
        settle();
        next();
        ramstate = ERROR;
        settle();
        check("e_state_ig", 32'(dbg_state), 32'd1);
        check("e_iwait", 32'(iwait), 32'd1);
        check("e_err_before", 32'(err), 32'd0);
        next();
        ramstate = FREE;
        settle();
        check("e_state_idle", 32'(dbg_state), 32'd0);
        check("e_err", 32'(err), 32'd1);
        check("e_iwait_idle", 32'(iwait), 32'd1);
        next();
        ramstate = BUSY;
        settle();
        check("e_regrant", 32'(dbg_state), 32'd1);
        check("e_regrant_ramREN", 32'(ramREN), 32'd1);
        next();
        drive_access(1'b0);
        settle();
        check("e_done", 32'(iwait), 32'd0);
        next();
        idle_inputs();
        settle();
        check("e_err_sticky", 32'(err), 32'd1);
        next();

        // ACCESS in the same cycle the counter hits its limit: completion, no err
        do_reset();
        settle();
        check("t_err_cleared", 32'(err), 32'd0);
        dREN = 1'b1;
        daddr = 32'h80;
        next();
        ramstate = BUSY;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("tb_state_dg", 32'(dbg_state), 32'd2);
            check("tb_dwait", 32'(dwait), 32'd1);
            next();
        end
        drive_access(1'b1);
        settle();
        check("tb_done", 32'(dwait), 32'd0);
        next();
        idle_inputs();
        settle();
        check("tb_no_err", 32'(err), 32'd0);
        check("tb_state_idle", 32'(dbg_state), 32'd0);
        next();

        // timeout: BUSY held for 4 grant cycles
        dREN = 1'b1;
        daddr = 32'h84;
        settle();
        next();
        ramstate = BUSY;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("to_state_dg", 32'(dbg_state), 32'd2);
            check("to_dwait", 32'(dwait), 32'd1);
            check("to_err_pending", 32'(err), 32'd0);
            next();
        end
        dREN = 1'b0;
        ramstate = FREE;
        settle();
        check("to_state_idle", 32'(dbg_state), 32'd0);
        check("to_err", 32'(err), 32'd1);
        check("to_dwait_idle", 32'(dwait), 32'd1);
        for (int k = 0; k < 3; k++) begin
            next();
            settle();
            check("to_err_held", 32'(err), 32'd1);
        end
        next();

        // reset in the 2nd DGRANT cycle aborts; next simultaneous request goes to data
        do_reset();
        dWEN = 1'b1;
        daddr = 32'h90;
        dstore = 32'h77;
        settle();
        next();
        ramstate = BUSY;
        settle();
        check("r_state_dg", 32'(dbg_state), 32'd2);
        next();
        RST = 1'b1;
        settle();
        check("r_dwait_in_rst", 32'(dwait), 32'd1);
        next();
        RST = 1'b0;
        dWEN = 1'b0;
        dREN = 1'b1;
        daddr = 32'h98;
        iREN = 1'b1;
        iaddr = 32'h94;
        ramstate = FREE;
        settle();
        check("r_state_idle", 32'(dbg_state), 32'd0);
        check("r_ramWEN", 32'(ramWEN), 32'd0);
        check("r_dwait", 32'(dwait), 32'd1);
        check("r_err", 32'(err), 32'd0);
        check("r_last_d", 32'(dbg_last_d), 32'd0);
        next();
        ramstate = BUSY;
        settle();
        check("r_data_first", 32'(dbg_state), 32'd2);
        check("r_ramREN", 32'(ramREN), 32'd1);
        check("r_ramaddr", ramaddr, 32'h98);
        next();
        drive_access(1'b1);
        settle();
        check("r_done", 32'(dwait), 32'd0);
        next();
        idle_inputs();
        settle();
        check("r_last_d_set", 32'(dbg_last_d), 32'd1);
        next();

        // final report
        check("iq_empty", 32'(iexp_q.size()), 32'd0);
        check("dq_empty", 32'(dexp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
